// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq_hz, input int baud);
    return (clk_freq_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head shows the oldest entry while non-empty.
// A push that finds the FIFO full (and no pop that cycle) is dropped and flagged on overrun.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x-oversampled RS-232 receiver feeding a FWFT byte FIFO for the port 0x01/0x02 read path.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and stop.
//
// state     | meaning
// IDLE      | waiting for a start edge (only once armed)
// START     | confirming the start bit at mid-bit
// DATA      | shifting in 8 data bits, LSB first
// PARITY    | sampling the parity bit (parity build only)
// STOP      | sampling stop bit; push byte or flag error
// WAIT_HIGH | line held low after a bad stop bit; wait for idle
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs232_rx,
  output logic [7:0] rx_data_out,
  output logic       rx_data_present,
  input  logic       read_rx_data_ack,
  output logic       rx_fifo_full,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       parity_error
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV - 1);
  localparam logic [3:0]    LAST_TICK  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    MID_TICK   = 4'(MID_SAMPLE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_sync;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          start_edge;
  logic          armed;
  logic          low_seen;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          push;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rs232_rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick       = (div_cnt == '0);
  assign start_edge = (state == IDLE) && armed && !rx_sync;

  // Down-counter reloads on the start edge so every sample is phase-aligned to it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    div_cnt <= DIV_RELOAD;
    else if (start_edge || tick)  div_cnt <= DIV_RELOAD;
    else                          div_cnt <= div_cnt - 1'b1;
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      armed         <= 1'b0;
      low_seen      <= 1'b0;
      tick_cnt      <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      push          <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      push          <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      // Arm only after a full tick interval of idle line, so a frame cut by reset is ignored.
      if (!armed) begin
        if (tick) begin
          armed    <= rx_sync && !low_seen;
          low_seen <= 1'b0;
        end else if (!rx_sync) begin
          low_seen <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (armed && !rx_sync) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_sync ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_sync, shift_reg[7:1]};
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt   <= '0;
              parity_bit <= rx_sync;
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (rx_sync) begin
                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (^{shift_reg, parity_bit}) parity_error <= 1'b1;
                else                          push         <= 1'b1;
`else
                push <= 1'b1;
`endif
              end else begin
                framing_error <= 1'b1;
                state         <= WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_reg),
    .pop       (read_rx_data_ack),
    .head      (rx_data_out),
    .full      (rx_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overrun   (overrun_error)
  );

  assign rx_data_present = !fifo_empty;
  // Occupancy is only needed by a future TX-side user of the FIFO.
  assign unused_count    = ^fifo_count;

endmodule
